// File: rtl/ram_cmd_feeder_pkg.sv
// ram_cmd_feeder_pkg: field widths, unsolved-token layout and feeder FSM states
package ram_cmd_feeder_pkg;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 9;
  localparam int MASK_W = 8;
  localparam int OFF_W = 16;
  localparam int TOKEN_W = 33;
  localparam int TOK_ADDR_HI = 32;
  localparam int TOK_ADDR_LO = 24;
  localparam int TOK_MASK_HI = 23;
  localparam int TOK_MASK_LO = 16;
  localparam int TOK_OFF_HI = 15;
  localparam int TOK_OFF_LO = 0;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} feeder_state_e;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] mask;
    logic [OFF_W-1:0] offset;
  } rd_cmd_t;
  function automatic rd_cmd_t unpack_token(input logic [TOKEN_W-1:0] t);
    return rd_cmd_t'{addr: t[TOK_ADDR_HI:TOK_ADDR_LO], mask: t[TOK_MASK_HI:TOK_MASK_LO], offset: t[TOK_OFF_HI:TOK_OFF_LO]};
  endfunction
endpackage

// File: rtl/ram_cmd_feeder_if.sv
// ram_cmd_feeder_if: request, unsolved-feedback, flush and ram command signals of the feeder
interface ram_cmd_feeder_if;
  import ram_cmd_feeder_pkg::*;
  logic lit_req_valid;
  logic lit_req_ready;
  logic [DATA_W-1:0] lit_req_data;
  logic [ADDR_W-1:0] lit_req_addr;
  logic [MASK_W-1:0] lit_req_mask;
  logic cp_req_valid;
  logic cp_req_ready;
  logic [ADDR_W-1:0] cp_req_addr;
  logic [MASK_W-1:0] cp_req_mask;
  logic [OFF_W-1:0] cp_req_offset;
  logic unsolved_valid_in;
  logic [TOKEN_W-1:0] unsolved_data_in;
  logic unsolved_rd;
  logic unsolved_half_full;
  logic ram_almost_full;
  logic ram_empty;
  logic flush_req;
  logic flush_done;
  logic valid_wr_out;
  logic [DATA_W-1:0] lit_out;
  logic [ADDR_W-1:0] lit_address_out;
  logic [MASK_W-1:0] lit_valid_out;
  logic valid_rd_out;
  logic [ADDR_W-1:0] copy_address_out;
  logic [MASK_W-1:0] copy_valid_out;
  logic [OFF_W-1:0] copy_offset_out;
  modport slave (
    input lit_req_valid, lit_req_data, lit_req_addr, lit_req_mask,
    input cp_req_valid, cp_req_addr, cp_req_mask, cp_req_offset,
    input unsolved_valid_in, unsolved_data_in, unsolved_half_full,
    input ram_almost_full, ram_empty, flush_req,
    output lit_req_ready, cp_req_ready, unsolved_rd, flush_done,
    output valid_wr_out, lit_out, lit_address_out, lit_valid_out,
    output valid_rd_out, copy_address_out, copy_valid_out, copy_offset_out
  );
  modport master (
    output lit_req_valid, lit_req_data, lit_req_addr, lit_req_mask,
    output cp_req_valid, cp_req_addr, cp_req_mask, cp_req_offset,
    output unsolved_valid_in, unsolved_data_in, unsolved_half_full,
    output ram_almost_full, ram_empty, flush_req,
    input lit_req_ready, cp_req_ready, unsolved_rd, flush_done,
    input valid_wr_out, lit_out, lit_address_out, lit_valid_out,
    input valid_rd_out, copy_address_out, copy_valid_out, copy_offset_out
  );
endinterface

// File: rtl/ram_cmd_feeder_rd_arbiter.sv
// ram_cmd_feeder_rd_arbiter: copy vs unsolved-token read select with a starvation counter
module ram_cmd_feeder_rd_arbiter #(
  parameter logic [7:0] STARVE_LIMIT = 8'd16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic u_open,
  input  logic cp_open,
  input  logic cp_valid,
  input  logic unsolved_valid,
  input  logic unsolved_half_full,
  output logic cp_ready,
  output logic unsolved_rd
);
  logic [7:0] starve_q, starve_d;
  logic cp_win;
  always_comb begin
    unsolved_rd = u_open & unsolved_valid & (unsolved_half_full | (starve_q >= STARVE_LIMIT) | ~(cp_valid & cp_open));
    cp_ready = cp_open & ~unsolved_rd;
    cp_win = cp_valid & cp_ready;
    starve_d = (~unsolved_valid | unsolved_rd) ? 8'd0 : cp_win ? starve_q + {7'd0, starve_q != 8'hFF} : starve_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) starve_q <= 8'd0;
    else starve_q <= starve_d;
  end
endmodule

// File: rtl/ram_cmd_feeder.sv
// ram_cmd_feeder: issues literal writes and copy/unsolved reads to a ram_module with backpressure and flush drain
module ram_cmd_feeder
  import ram_cmd_feeder_pkg::*;
#(
  parameter logic [7:0] STARVE_LIMIT = 8'd16,
  parameter logic [3:0] QUIET_CYCLES = 4'd4
) (
  input logic clk,
  input logic rst_n,
  ram_cmd_feeder_if.slave bus
);
  feeder_state_e state_q, state_d;
  logic [3:0] quiet_q, quiet_d;
  logic wr_valid_q, wr_valid_d, rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] lit_q, lit_d;
  logic [ADDR_W-1:0] lit_addr_q, lit_addr_d;
  logic [MASK_W-1:0] lit_mask_q, lit_mask_d;
  rd_cmd_t rd_q, rd_d, rd_sel;
  logic u_open, cp_open, lit_acc, rd_acc, cp_ready, unsolved_rd;
  always_comb begin
    u_open = rst_n & ~bus.ram_almost_full;
    cp_open = u_open & (state_q == RUN);
  end
  ram_cmd_feeder_rd_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .u_open(u_open),
    .cp_open(cp_open),
    .cp_valid(bus.cp_req_valid),
    .unsolved_valid(bus.unsolved_valid_in),
    .unsolved_half_full(bus.unsolved_half_full),
    .cp_ready(cp_ready),
    .unsolved_rd(unsolved_rd)
  );
  always_comb begin
    bus.lit_req_ready = cp_open;
    bus.cp_req_ready = cp_ready;
    bus.unsolved_rd = unsolved_rd;
    bus.flush_done = rst_n & (state_q == DONE);
    bus.valid_wr_out = wr_valid_q;
    bus.lit_out = lit_q;
    bus.lit_address_out = lit_addr_q;
    bus.lit_valid_out = lit_mask_q;
    bus.valid_rd_out = rd_valid_q;
    bus.copy_address_out = rd_q.addr;
    bus.copy_valid_out = rd_q.mask;
    bus.copy_offset_out = rd_q.offset;
    lit_acc = bus.lit_req_valid & cp_open;
    wr_valid_d = lit_acc & (bus.lit_req_mask != '0);
    lit_d = wr_valid_d ? bus.lit_req_data : lit_q;
    lit_addr_d = wr_valid_d ? bus.lit_req_addr : lit_addr_q;
    lit_mask_d = wr_valid_d ? bus.lit_req_mask : lit_mask_q;
    rd_sel = unsolved_rd ? unpack_token(bus.unsolved_data_in)
                         : rd_cmd_t'{addr: bus.cp_req_addr, mask: bus.cp_req_mask, offset: bus.cp_req_offset};
    rd_acc = unsolved_rd | (bus.cp_req_valid & cp_ready);
    rd_valid_d = rd_acc & (rd_sel.mask != '0);
    rd_d = rd_valid_d ? rd_sel : rd_q;
    quiet_d = ((state_q == DRAIN) & bus.ram_empty & ~bus.unsolved_valid_in & ~wr_valid_q & ~rd_valid_q) ? quiet_q + 4'd1 : 4'd0;
    state_d = state_q;
    case (state_q)
      RUN: if (bus.flush_req) state_d = DRAIN;
      DRAIN: if (quiet_d == QUIET_CYCLES) state_d = DONE;
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      quiet_q <= 4'd0;
      wr_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      lit_q <= '0;
      lit_addr_q <= '0;
      lit_mask_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      quiet_q <= quiet_d;
      wr_valid_q <= wr_valid_d;
      rd_valid_q <= rd_valid_d;
      lit_q <= lit_d;
      lit_addr_q <= lit_addr_d;
      lit_mask_q <= lit_mask_d;
      rd_q <= rd_d;
    end
  end
endmodule

// File: tb/tb_ram_cmd_feeder.sv
// tb_ram_cmd_feeder: scoreboard bench with a transaction-level model of the feeder
module tb_ram_cmd_feeder;
  typedef struct packed {
    bit lv; logic [63:0] ld; logic [8:0] la; logic [7:0] lm;
    bit cv; logic [8:0] ca; logic [7:0] cm; logic [15:0] co;
    bit hf; bit af; bit re; bit fl; bit rn;
  } stim_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ram_cmd_feeder_if bus();
  ram_cmd_feeder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int fails = 0;
  logic [80:0] wq[$];
  logic [32:0] rq[$];
  logic [32:0] tq[$];
  int m_mode = 0;
  int m_loss = 0;
  int m_quiet = 0;
  bit m_prev = 0;
  function automatic void chk(string n, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h @%0t", n, act, exp, $time);
    end
  endfunction
  function automatic stim_t idle();
    stim_t s = '0;
    s.rn = 1;
    return s;
  endfunction
  function automatic logic [32:0] rtok();
    logic [7:0] m = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
    return {9'($urandom), m, 16'($urandom)};
  endfunction
  function automatic stim_t rstim();
    stim_t s = idle();
    s.lv = 1'($urandom); s.ld = {$urandom, $urandom}; s.la = 9'($urandom);
    s.lm = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
    s.cv = 1'($urandom); s.ca = 9'($urandom); s.co = 16'($urandom);
    s.cm = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
    s.hf = ($urandom % 4 == 0); s.af = ($urandom % 5 == 0);
    s.re = ($urandom % 3 != 0); s.fl = ($urandom % 40 == 0);
    return s;
  endfunction
  task automatic step(input stim_t s);
    bit uv, run, cp_ok, take_u, take_c, issued;
    logic [32:0] tok;
    @(negedge clk);
    rst_n = s.rn;
    bus.lit_req_valid = s.lv; bus.lit_req_data = s.ld; bus.lit_req_addr = s.la; bus.lit_req_mask = s.lm;
    bus.cp_req_valid = s.cv; bus.cp_req_addr = s.ca; bus.cp_req_mask = s.cm; bus.cp_req_offset = s.co;
    bus.unsolved_half_full = s.hf; bus.ram_almost_full = s.af; bus.ram_empty = s.re; bus.flush_req = s.fl;
    bus.unsolved_valid_in = tq.size() != 0;
    bus.unsolved_data_in = tq.size() != 0 ? tq[0] : 33'h0;
    #1;
    if (!s.rn) begin
      chk("rst_lit_ready", bus.lit_req_ready, 0);
      chk("rst_cp_ready", bus.cp_req_ready, 0);
      chk("rst_unsolved_rd", bus.unsolved_rd, 0);
      chk("rst_flush_done", bus.flush_done, 0);
      wq.delete(); rq.delete();
      m_mode = 0; m_loss = 0; m_quiet = 0; m_prev = 0;
      return;
    end
    uv = tq.size() != 0;
    run = m_mode == 0;
    cp_ok = s.cv && !s.af && run;
    take_u = uv && !s.af && (s.hf || m_loss >= 16 || !cp_ok);
    take_c = cp_ok && !take_u;
    chk("lit_ready", bus.lit_req_ready, !s.af && run);
    chk("cp_ready", bus.cp_req_ready, !s.af && run && !take_u);
    chk("unsolved_rd", bus.unsolved_rd, take_u);
    chk("flush_done", bus.flush_done, m_mode == 2);
    issued = 0;
    if (s.lv && !s.af && run && s.lm != 0) begin wq.push_back({s.ld, s.la, s.lm}); issued = 1; end
    if (take_u) begin
      tok = tq.pop_front();
      if (tok[23:16] != 0) begin rq.push_back(tok); issued = 1; end
    end else if (take_c && s.cm != 0) begin
      rq.push_back({s.ca, s.cm, s.co}); issued = 1;
    end
    m_loss = (!uv || take_u) ? 0 : take_c ? (m_loss == 255 ? 255 : m_loss + 1) : m_loss;
    if (m_mode == 0) begin
      if (s.fl) begin m_mode = 1; m_quiet = 0; end
    end else if (m_mode == 1) begin
      m_quiet = (s.re && !uv && !m_prev) ? m_quiet + 1 : 0;
      if (m_quiet == 4) m_mode = 2;
    end else m_mode = 0;
    m_prev = issued;
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (bus.valid_wr_out === 1'b1) begin
        if (wq.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("wr_cmd", {bus.lit_out, bus.lit_address_out, bus.lit_valid_out}, wq.pop_front());
      end
      if (bus.valid_rd_out === 1'b1) begin
        if (rq.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_cmd", {bus.copy_address_out, bus.copy_valid_out, bus.copy_offset_out}, rq.pop_front());
      end
      chk("wr_missing", wq.size(), 0);
      chk("rd_missing", rq.size(), 0);
      wq.delete(); rq.delete();
    end
  end
  initial begin
    stim_t s;
    int first, pulses;
    s = idle(); s.rn = 0;
    step(s); step(s);
    @(posedge clk); #2;
    chk("reset_outputs", {bus.valid_wr_out, bus.valid_rd_out, bus.lit_out, bus.lit_address_out, bus.lit_valid_out,
                          bus.copy_address_out, bus.copy_valid_out, bus.copy_offset_out}, 0);
    s = idle(); s.lv = 1; s.ld = 64'hDEADBEEF_01234567; s.la = 9'h010; s.lm = 8'hFF;
    step(s);
    s.lm = 8'h00; s.ld = 64'h1; step(s);
    step(idle());
    first = 0;
    tq.push_back(33'h0_0AB_33_1234);
    for (int i = 1; i <= 20 && first == 0; i++) begin
      s = idle(); s.cv = 1; s.ca = 9'(i); s.cm = 8'h0F; s.co = 16'(i);
      step(s);
      if (bus.unsolved_rd) first = i;
    end
    chk("starve_win_cycle", first, 17);
    step(idle());
    tq.push_back(33'h0_1FF_0A_0040); tq.push_back(rtok()); tq.push_back(rtok());
    s = idle(); s.cv = 1; s.cm = 8'hF0; s.hf = 1;
    step(s);
    @(posedge clk); #2;
    chk("token_unpack", {bus.copy_address_out, bus.copy_valid_out, bus.copy_offset_out}, {9'h1FF, 8'h0A, 16'h0040});
    step(s); step(s); step(s);
    tq.push_back(rtok()); tq.push_back(rtok());
    s = idle(); s.lv = 1; s.lm = 8'h3C; s.ld = 64'hCAFE; s.cv = 1; s.cm = 8'h81; s.hf = 1; s.af = 1;
    repeat (5) step(s);
    s.af = 0;
    repeat (3) step(s);
    repeat (3) tq.push_back({9'h055, 8'h11, 16'h0100});
    s = idle(); s.fl = 1;
    step(s);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      s = idle(); s.lv = 1; s.lm = 8'hFF; s.ld = 64'(i); s.cv = 1; s.cm = 8'h0F; s.re = tq.size() == 0;
      step(s);
      if (bus.flush_done) pulses++;
      if (pulses != 0 && m_mode == 0) break;
    end
    chk("flush_pulses", pulses, 1);
    chk("flush_tokens_left", tq.size(), 0);
    step(idle());
    s = idle(); s.fl = 1; step(s);
    step(idle()); step(idle());
    s = idle(); s.rn = 0; s.lv = 1; s.lm = 8'hFF; step(s);
    @(posedge clk); #2;
    chk("reset_drain_outputs", {bus.valid_wr_out, bus.valid_rd_out, bus.flush_done, bus.lit_out, bus.copy_offset_out}, 0);
    s.rn = 1; s.re = 1;
    repeat (6) step(s);
    for (int i = 0; i < 500; i++) begin
      if (tq.size() < 5 && $urandom % 3 == 0) tq.push_back(rtok());
      step(rstim());
    end
    repeat (3) step(idle());
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
